lcd_ctrl: RTL and testbench

- Downstream consumer of the output peripheral's LCD register.
- Accepts byte writes (command or character) from the store path into a small FIFO.
- Replays each byte to an HD44780-compatible character LCD with correct setup, enable-pulse, hold and execution timing.
- Lets software issue back-to-back LCD stores without polling or software delay loops.

---
 rtl/lcd_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: queues LCD command/data bytes and replays them to an HD44780 with setup/EN/hold/exec timing.
// Optional LCD_INIT_EN adds a power-up wait and the 0x38/0x0C/0x01/0x06 init sequence before user bytes.
module lcd_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int T_SETUP     = 4,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 1850,
    parameter int T_EXEC_LONG = 76000,
    parameter int T_PWRUP     = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_en,
    input  logic [8:0] i_wr_data,
    output logic       o_full,
    output logic       o_busy,
    output logic       o_ovf,
    output logic       o_init_done,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int T_MAX = (T_EXEC_LONG > T_PWRUP) ? T_EXEC_LONG : T_PWRUP;
    localparam int CW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_PWRUP, S_INIT
    } state_t;

    logic [8:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_long;
    state_t        r_state;
    logic [CW-1:0] r_tmr;

    assign w_push   = i_wr_en && !o_full;
    assign w_pop    = (r_state == S_IDLE) && (r_cnt != '0) && o_init_done;
    // Clear display / return home need the long execution time.
    assign w_long   = !o_lcd_rs && (o_lcd_data == 8'h01 || o_lcd_data == 8'h02 || o_lcd_data == 8'h03);
    assign o_busy   = (r_state != S_IDLE) || (r_cnt != '0) || !o_init_done;
    assign o_lcd_rw = 1'b0;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + 1'b1;
        else if (w_pop && !w_push)
            w_cnt_nxt = r_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            o_full <= 1'b0;
            o_ovf  <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (i_wr_en && o_full)
                o_ovf <= 1'b1;
            r_cnt  <= w_cnt_nxt;
            o_full <= (w_cnt_nxt == (AW+1)'(FIFO_DEPTH));
        end
    end

`ifdef LCD_INIT_EN
    logic [2:0] r_init_idx;

    function automatic logic [7:0] f_init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef LCD_INIT_EN
            r_state    <= S_PWRUP;
            r_tmr      <= CW'(T_PWRUP - 1);
            r_init_idx <= '0;
`else
            r_state    <= S_IDLE;
            r_tmr      <= '0;
`endif
            o_lcd_data  <= '0;
            o_lcd_rs    <= 1'b0;
            o_lcd_en    <= 1'b0;
            o_lcd_on    <= 1'b0;
            o_init_done <= 1'b0;
        end else begin
            o_lcd_on <= 1'b1;
`ifndef LCD_INIT_EN
            o_init_done <= 1'b1;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        o_lcd_data <= r_mem[r_rp][7:0];
                        o_lcd_rs   <= r_mem[r_rp][8];
                        r_tmr      <= CW'(T_SETUP - 1);
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_tmr == '0) begin
                        o_lcd_en <= 1'b1;
                        r_tmr    <= CW'(T_EN - 1);
                        r_state  <= S_PULSE;
                    end else
                        r_tmr <= r_tmr - 1'b1;
                end
                S_PULSE: begin
                    if (r_tmr == '0) begin
                        o_lcd_en <= 1'b0;
                        r_tmr    <= CW'(T_HOLD - 1);
                        r_state  <= S_HOLD;
                    end else
                        r_tmr <= r_tmr - 1'b1;
                end
                S_HOLD: begin
                    if (r_tmr == '0) begin
                        r_tmr   <= w_long ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
                        r_state <= S_EXEC;
                    end else
                        r_tmr <= r_tmr - 1'b1;
                end
                S_EXEC: begin
                    if (r_tmr == '0) begin
`ifdef LCD_INIT_EN
                        if (!o_init_done && r_init_idx != 3'd4)
                            r_state <= S_INIT;
                        else begin
                            o_init_done <= 1'b1;
                            r_state     <= S_IDLE;
                        end
`else
                        r_state <= S_IDLE;
`endif
                    end else
                        r_tmr <= r_tmr - 1'b1;
                end
`ifdef LCD_INIT_EN
                S_PWRUP: begin
                    if (r_tmr == '0)
                        r_state <= S_INIT;
                    else
                        r_tmr <= r_tmr - 1'b1;
                end
                S_INIT: begin
                    o_lcd_data <= f_init_byte(r_init_idx);
                    o_lcd_rs   <= 1'b0;
                    r_init_idx <= r_init_idx + 1'b1;
                    r_tmr      <= CW'(T_SETUP - 1);
                    r_state    <= S_SETUP;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters; EN rising edges are logged with {init_done, rs, data}.
module tb_lcd_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_wr_en;
    logic [8:0] i_wr_data;
    logic       o_full, o_busy, o_ovf, o_init_done;
    logic [7:0] o_lcd_data;
    logic       o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic       prev_en = 1'b0;
    logic [9:0] ev_q[$];
    int         ev_cyc[$];

    lcd_ctrl #(
        .FIFO_DEPTH(4), .T_SETUP(2), .T_EN(3), .T_HOLD(2),
        .T_EXEC(5), .T_EXEC_LONG(20), .T_PWRUP(10)
    ) dut (
        .clk(clk), .rst(rst), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
        .o_full(o_full), .o_busy(o_busy), .o_ovf(o_ovf), .o_init_done(o_init_done),
        .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_lcd_en && !prev_en) begin
            ev_q.push_back({o_init_done, o_lcd_rs, o_lcd_data});
            ev_cyc.push_back(cyc);
        end
        prev_en <= o_lcd_en;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [8:0] d);
        i_wr_en   = 1'b1;
        i_wr_data = d;
        @(negedge clk);
        i_wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (o_busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(o_busy), 32'd0);
    endtask

    task automatic clear_log();
        ev_q.delete();
        ev_cyc.delete();
    endtask

`ifdef LCD_INIT_EN
    task automatic wait_init(input string tag);
        int n = 0;
        while (!o_init_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(o_init_done), 32'd1);
        wait_idle({tag, "_idle"}, 50);
    endtask
`endif

    task automatic chk_log(input string tag, input logic [9:0] exp[$]);
        chk({tag, "_n"}, ev_q.size(), exp.size());
        if (ev_q.size() == exp.size())
            for (int i = 0; i < exp.size(); i++)
                chk($sformatf("%s_%0d", tag, i), 32'(ev_q[i]), 32'(exp[i]));
    endtask

    task automatic chk_gap(input string tag, input int exp);
        chk({tag, "_n"}, ev_cyc.size(), 2);
        if (ev_cyc.size() == 2)
            chk(tag, ev_cyc[1] - ev_cyc[0], exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] exp_q[$];
        int n;
        rst = 1'b1; i_wr_en = 1'b0; i_wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(o_lcd_data), 0);
        chk("rst_rs",   32'(o_lcd_rs), 0);
        chk("rst_rw",   32'(o_lcd_rw), 0);
        chk("rst_en",   32'(o_lcd_en), 0);
        chk("rst_on",   32'(o_lcd_on), 0);
        chk("rst_ovf",  32'(o_ovf), 0);
        chk("rst_full", 32'(o_full), 0);
        chk("rst_init", 32'(o_init_done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("on_after_rst", 32'(o_lcd_on), 1);
`ifdef LCD_INIT_EN
        chk("init_after_rst", 32'(o_init_done), 0);
        wait_init("init0");
`else
        chk("init_after_rst", 32'(o_init_done), 1);
`endif
        chk("busy_idle", 32'(o_busy), 0);
        clear_log();

        // Single character write: setup 2, EN 3, hold 2, exec 5.
        wr(9'h141);
        chk("t2_busy0", 32'(o_busy), 1);
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            chk($sformatf("t2_en_%0d", i), 32'(o_lcd_en), (i >= 3 && i <= 5) ? 1 : 0);
            chk($sformatf("t2_dat_%0d", i), 32'(o_lcd_data), 32'h41);
            chk($sformatf("t2_rs_%0d", i), 32'(o_lcd_rs), 1);
            if (i >= 12)
                chk($sformatf("t2_busy_%0d", i), 32'(o_busy), (i == 13) ? 0 : 1);
        end

        // Clear command uses the long exec; 0x10 uses the normal one.
        clear_log();
        wr(9'h001);
        wr(9'h130);
        wait_idle("t3_idle_a", 100);
        chk_gap("t3_gap_clear", 28);
        exp_q = '{10'h201, 10'h330};
        chk_log("t3_log_a", exp_q);
        clear_log();
        wr(9'h010);
        wr(9'h130);
        wait_idle("t3_idle_b", 100);
        chk_gap("t3_gap_shift", 13);

        // Fill FIFO while the FSM is busy, overflow on the fifth write.
        clear_log();
        wr(9'h120);
        repeat (2) @(negedge clk);
        wr(9'h131); wr(9'h132); wr(9'h133);
        chk("t4_full3", 32'(o_full), 0);
        wr(9'h134);
        chk("t4_full4", 32'(o_full), 1);
        chk("t4_ovf4",  32'(o_ovf), 0);
        wr(9'h135);
        chk("t4_ovf5",  32'(o_ovf), 1);
        chk("t4_full5", 32'(o_full), 1);
        wait_idle("t4_idle", 200);
        chk("t4_ovf_sticky", 32'(o_ovf), 1);
        chk("t4_full_end", 32'(o_full), 0);
        exp_q = '{10'h320, 10'h331, 10'h332, 10'h333, 10'h334};
        chk_log("t4_log", exp_q);

        // Reset while EN is high with another byte still queued.
        wr(9'h155);
        wr(9'h156);
        n = 0;
        while (!o_lcd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_en_seen", 32'(o_lcd_en), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_en",   32'(o_lcd_en), 0);
        chk("t5_ovf",  32'(o_ovf), 0);
        chk("t5_full", 32'(o_full), 0);
        chk("t5_data", 32'(o_lcd_data), 0);
        rst = 1'b0;
        @(negedge clk);
`ifdef LCD_INIT_EN
        wait_init("t5_init");
`endif
        clear_log();
        repeat (30) @(negedge clk);
        chk("t5_no_pulse", ev_q.size(), 0);
        chk("t5_busy", 32'(o_busy), 0);

        // Write right after reset release: init sequence (if built) precedes the user byte.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        @(negedge clk);
        wr(9'h148);
        wait_idle("t6_idle", 500);
`ifdef LCD_INIT_EN
        exp_q = '{10'h038, 10'h00C, 10'h001, 10'h006, 10'h348};
`else
        exp_q = '{10'h348};
`endif
        chk_log("t6_log", exp_q);
        chk("t6_init_done", 32'(o_init_done), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
